// File: rtl/demux8_reg.sv
// demux8_reg: registered 1-to-8 demultiplexer with per-slot valid/ack handshake.
//
// Each write lands in one of eight data slots and marks that slot valid. A consumer
// acknowledges a slot to hide it again; the data stays in the register but reads as zero.
// Overwriting a slot that is still valid and not being consumed raises a sticky overflow.
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset (clears data, valid, overflow)
//   enable    active-low write enable (0 = write)
//   addr      destination slot for a write
//   in        write data
//   ack       per-slot consume request
//   clear     synchronous flush of valid flags and overflow (data retained)
//   out0..7   slot data, forced to zero while the slot is invalid
//   valid     per-slot valid flags
//   count     number of valid slots (0..8)
//   overflow  sticky flag: a valid, unconsumed slot was overwritten
module demux8_reg #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic [2:0]       addr,
   input  logic [WIDTH-1:0] in,
   input  logic [7:0]       ack,
   input  logic             clear,
   output logic [WIDTH-1:0] out0,
   output logic [WIDTH-1:0] out1,
   output logic [WIDTH-1:0] out2,
   output logic [WIDTH-1:0] out3,
   output logic [WIDTH-1:0] out4,
   output logic [WIDTH-1:0] out5,
   output logic [WIDTH-1:0] out6,
   output logic [WIDTH-1:0] out7,
   output logic [7:0]       valid,
   output logic [3:0]       count,
   output logic             overflow
);

   logic [WIDTH-1:0] data_q [8];
   logic [7:0]       valid_q;
   logic [7:0]       valid_d;
   logic             overflow_q;
   logic             overflow_d;
   logic             wr;
   logic [7:0]       wr_sel;

   // addr is only decoded when a write is requested, so an unknown addr while
   // enable is high never reaches the state.
   assign wr = ~enable;

   always_comb begin
      wr_sel = 8'h00;
      if (wr) begin
         unique case (addr)
            3'd0:    wr_sel = 8'h01;
            3'd1:    wr_sel = 8'h02;
            3'd2:    wr_sel = 8'h04;
            3'd3:    wr_sel = 8'h08;
            3'd4:    wr_sel = 8'h10;
            3'd5:    wr_sel = 8'h20;
            3'd6:    wr_sel = 8'h40;
            default: wr_sel = 8'h80;
         endcase
      end
   end

   // Priority per slot: write > ack; clear flushes first, then the write re-validates.
   always_comb begin
      valid_d    = valid_q;
      overflow_d = overflow_q;

      if (clear) begin
         valid_d    = 8'h00;
         overflow_d = 1'b0;
      end else begin
         for (int i = 0; i < 8; i++) begin
            if (ack[i] && valid_q[i] && !wr_sel[i]) begin
               valid_d[i] = 1'b0;
            end
            // An ack in the same cycle counts as consuming the old value.
            if (wr_sel[i] && valid_q[i] && !ack[i]) begin
               overflow_d = 1'b1;
            end
         end
      end

      valid_d = valid_d | wr_sel;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) begin
            data_q[i] <= '0;
         end
         valid_q    <= 8'h00;
         overflow_q <= 1'b0;
      end else begin
         for (int i = 0; i < 8; i++) begin
            if (wr_sel[i]) begin
               data_q[i] <= in;
            end
         end
         valid_q    <= valid_d;
         overflow_q <= overflow_d;
      end
   end

   always_comb begin
      count = 4'd0;
      for (int i = 0; i < 8; i++) begin
         count = count + 4'(valid_q[i]);
      end
   end

   assign out0     = valid_q[0] ? data_q[0] : '0;
   assign out1     = valid_q[1] ? data_q[1] : '0;
   assign out2     = valid_q[2] ? data_q[2] : '0;
   assign out3     = valid_q[3] ? data_q[3] : '0;
   assign out4     = valid_q[4] ? data_q[4] : '0;
   assign out5     = valid_q[5] ? data_q[5] : '0;
   assign out6     = valid_q[6] ? data_q[6] : '0;
   assign out7     = valid_q[7] ? data_q[7] : '0;
   assign valid    = valid_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_demux8_reg.sv
module tb_demux8_reg;

   localparam int unsigned WIDTH = 32;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             enable = 1'b1;
   logic [2:0]       addr = 3'd0;
   logic [WIDTH-1:0] din = '0;
   logic [7:0]       ack = 8'h00;
   logic             clear = 1'b0;
   logic [WIDTH-1:0] out0, out1, out2, out3, out4, out5, out6, out7;
   logic [7:0]       valid;
   logic [3:0]       count;
   logic             overflow;

   logic [WIDTH-1:0] dut_out [8];
   assign dut_out[0] = out0;
   assign dut_out[1] = out1;
   assign dut_out[2] = out2;
   assign dut_out[3] = out3;
   assign dut_out[4] = out4;
   assign dut_out[5] = out5;
   assign dut_out[6] = out6;
   assign dut_out[7] = out7;

   demux8_reg #(.WIDTH(WIDTH)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .enable   (enable),
      .addr     (addr),
      .in       (din),
      .ack      (ack),
      .clear    (clear),
      .out0     (out0),
      .out1     (out1),
      .out2     (out2),
      .out3     (out3),
      .out4     (out4),
      .out5     (out5),
      .out6     (out6),
      .out7     (out7),
      .valid    (valid),
      .count    (count),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: slot contents as plain arrays.
   logic [WIDTH-1:0] m_data [8];
   bit               m_valid [8];
   bit               m_ovf;

   task automatic check(input string name, input logic [WIDTH-1:0] act,
                        input logic [WIDTH-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) begin
         m_data[i]  = '0;
         m_valid[i] = 0;
      end
      m_ovf = 0;
   endtask

   // One clock edge of the rules, using the inputs held across the edge.
   task automatic model_step(input bit en_n, input int a, input logic [WIDTH-1:0] d,
                             input logic [7:0] k, input bit clr);
      bit we;
      bit old_v [8];
      we = !en_n;
      for (int i = 0; i < 8; i++) old_v[i] = m_valid[i];
      if (clr) begin
         for (int i = 0; i < 8; i++) m_valid[i] = 0;
         m_ovf = 0;
      end else begin
         for (int i = 0; i < 8; i++)
            if (k[i] && old_v[i] && !(we && a == i)) m_valid[i] = 0;
         if (we && old_v[a] && !k[a]) m_ovf = 1;
      end
      if (we) begin
         m_data[a]  = d;
         m_valid[a] = 1;
      end
   endtask

   function automatic logic [7:0] model_valid();
      logic [7:0] v;
      for (int i = 0; i < 8; i++) v[i] = m_valid[i];
      return v;
   endfunction

   task automatic check_model(input string tag);
      logic [7:0] v;
      int         c;
      v = model_valid();
      c = 0;
      for (int i = 0; i < 8; i++) if (m_valid[i]) c++;
      check({tag, ".valid"}, 32'(valid), 32'(v));
      check({tag, ".count"}, 32'(count), 32'(c));
      check({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
      for (int i = 0; i < 8; i++)
         check($sformatf("%s.out%0d", tag, i), dut_out[i], m_valid[i] ? m_data[i] : '0);
   endtask

   task automatic step(input bit en_n, input logic [2:0] a, input logic [WIDTH-1:0] d,
                       input logic [7:0] k, input bit clr);
      @(negedge clk);
      enable = en_n;
      addr   = a;
      din    = d;
      ack    = k;
      clear  = clr;
      @(posedge clk);
      #1;
      model_step(en_n, int'(a), d, k, clr);
      enable = 1'b1;
      ack    = 8'h00;
      clear  = 1'b0;
   endtask

   typedef struct {
      bit               en_n;
      logic [2:0]       a;
      logic [WIDTH-1:0] d;
      logic [7:0]       k;
      bit               clr;
      logic [7:0]       exp_valid;
      bit               exp_ovf;
      int               slot;
      logic [WIDTH-1:0] exp_out;
   } vec_t;

   vec_t vecs [$];

   initial begin
      model_reset();
      // Directed sequence from reset: first write, fill, overflow, write+ack, clear+write.
      vecs.push_back('{0, 3'd3, 32'hA5A5_0001, 8'h00, 0, 8'h08, 0, 3, 32'hA5A5_0001});
      vecs.push_back('{1, 3'd0, 32'h0,         8'h00, 1, 8'h00, 0, 3, 32'h0});
      for (int i = 0; i < 8; i++)
         vecs.push_back('{0, 3'(i), 32'(16 + i), 8'h00, 0, 8'((1 << (i + 1)) - 1), 0, i,
                          32'(16 + i)});
      vecs.push_back('{0, 3'd5, 32'h99, 8'h00, 0, 8'hFF, 1, 5, 32'h99});
      vecs.push_back('{1, 3'd1, 32'h0,  8'h00, 0, 8'hFF, 1, 5, 32'h99});
      vecs.push_back('{1, 3'd7, 32'h1,  8'h00, 0, 8'hFF, 1, 5, 32'h99});
      vecs.push_back('{1, 3'd0, 32'h0,  8'h00, 1, 8'h00, 0, 2, 32'h0});
      vecs.push_back('{0, 3'd2, 32'h22, 8'h00, 0, 8'h04, 0, 2, 32'h22});
      vecs.push_back('{0, 3'd2, 32'h55, 8'h04, 0, 8'h04, 0, 2, 32'h55});
      vecs.push_back('{1, 3'd0, 32'h0,  8'h04, 0, 8'h00, 0, 2, 32'h0});
      vecs.push_back('{1, 3'd0, 32'h0,  8'hF0, 0, 8'h00, 0, 4, 32'h0});
      for (int i = 0; i < 4; i++)
         vecs.push_back('{0, 3'(i), 32'(i + 1), 8'h00, 0, 8'((1 << (i + 1)) - 1), 0, i,
                          32'(i + 1)});
      vecs.push_back('{0, 3'd0, 32'hAA, 8'h00, 0, 8'h0F, 1, 0, 32'hAA});
      vecs.push_back('{0, 3'd6, 32'h77, 8'h00, 1, 8'h40, 0, 6, 32'h77});

      // Reset state.
      #12;
      check("reset.valid", 32'(valid), 32'h0);
      check("reset.count", 32'(count), 32'h0);
      check("reset.ovf", 32'(overflow), 32'h0);
      check("reset.out3", out3, '0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[j]) begin
         step(vecs[j].en_n, vecs[j].a, vecs[j].d, vecs[j].k, vecs[j].clr);
         check($sformatf("vec%0d.valid", j), 32'(valid), 32'(vecs[j].exp_valid));
         check($sformatf("vec%0d.count", j), 32'(count), 32'($countones(vecs[j].exp_valid)));
         check($sformatf("vec%0d.ovf", j), 32'(overflow), 32'(vecs[j].exp_ovf));
         check($sformatf("vec%0d.out", j), dut_out[vecs[j].slot], vecs[j].exp_out);
         check_model($sformatf("vec%0d", j));
      end

      // Enable held high: addr and data wiggle, nothing may change.
      step(0, 3'd1, 32'h1111, 8'h00, 0);
      for (int i = 0; i < 10; i++) begin
         step(1, 3'($urandom), $urandom, 8'h00, 0);
         check_model($sformatf("idle%0d", i));
      end

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         logic [7:0] k;
         k = 8'($urandom) & 8'($urandom) & 8'($urandom);
         step(($urandom_range(0, 3) == 0), 3'($urandom), $urandom, k,
              ($urandom_range(0, 24) == 0));
         check_model($sformatf("rnd%0d", i));
      end

      // Asynchronous reset mid-cycle with every slot full.
      for (int i = 0; i < 8; i++) step(0, 3'(i), 32'(32'hC0DE_0000 + i), 8'h00, 0);
      check("full.valid", 32'(valid), 32'hFF);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      ack   = 8'hFF;
      #1;
      model_reset();
      check("arst.valid", 32'(valid), 32'h0);
      check("arst.count", 32'(count), 32'h0);
      check("arst.ovf", 32'(overflow), 32'h0);
      check("arst.out7", out7, '0);
      @(posedge clk);
      #1;
      check_model("arst_hold");
      @(negedge clk);
      rst_n = 1'b1;
      ack   = 8'h00;
      // First write after release lands on the next edge.
      step(0, 3'd4, 32'hBEEF_0004, 8'h00, 0);
      check("post_rst.out4", out4, 32'hBEEF_0004);
      check_model("post_rst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/demux8_reg.md
DEMUX8_REG -- requirements
Module: demux8_reg

Interface
REQ-001 Parameter: WIDTH, default 32, data width of the input and of each of the eight outputs.
REQ-002 clk  input  1  sole clock; all state updates occur on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 enable  input  1  active-low write enable: 0 = write, 1 = no write.
REQ-005 addr  input  3  destination slot for a write, 3'b000..3'b111 selects slot 0..7.
REQ-006 in  input  WIDTH  write data.
REQ-007 ack  input  8  per-slot consumer acknowledge; ack[i]=1 consumes slot i.
REQ-008 clear  input  1  synchronous flush of all valid flags and the overflow flag.
REQ-009 out0..out7  output  WIDTH each  slot data, gated to zero while the slot is invalid.
REQ-010 valid  output  8  per-slot valid flag, registered.
REQ-011 count  output  4  number of valid slots, 0..8.
REQ-012 overflow  output  1  sticky flag, set when a valid unconsumed slot is overwritten.

Function
REQ-013 The block SHALL hold eight WIDTH-bit data registers data[0..7] and an 8-bit valid register.
REQ-014 On a rising clk edge with enable=0, data[addr] SHALL load in and valid[addr] SHALL be set to 1.
REQ-015 With enable=1, no data register SHALL change.
REQ-016 Write latency: data written at edge k SHALL appear on out<addr> with valid[addr]=1 immediately after edge k, with no further delay.
REQ-017 out_i SHALL equal data[i] when valid[i]=1 and all-zero when valid[i]=0 (combinational gating only).
REQ-018 On a rising edge, ack[i]=1 with valid[i]=1 and no write to slot i SHALL clear valid[i]; data[i] SHALL be retained but hidden.
REQ-019 ack[i]=1 with valid[i]=0 SHALL be ignored.
REQ-020 Simultaneous write to slot i and ack[i]=1: the write SHALL win, valid[i] SHALL remain 1, data[i] SHALL take the new value, and overflow SHALL NOT be set.
REQ-021 A write to slot i with valid[i]=1 and ack[i]=0 SHALL overwrite data[i] and set overflow to 1.
REQ-022 overflow SHALL remain 1 until reset or clear.
REQ-023 Acks on other slots SHALL be processed independently in the same cycle as a write.
REQ-024 clear=1 at an edge SHALL zero all valid bits and overflow, and SHALL leave data registers unchanged.
REQ-025 A simultaneous write with clear SHALL be applied after the flush: only valid[addr]=1 results, and overflow SHALL be 0.
REQ-026 count SHALL be the combinational population count of valid; count=8 SHALL indicate full, and further writes follow REQ-021.
REQ-027 X on addr while enable=1 SHALL NOT affect state.

Reset
REQ-028 rst_n=0 SHALL immediately, without waiting for a clk edge, set all data registers to 0, valid=8'h00 and overflow=0; hence out0..out7=0 and count=0.
REQ-029 Reset asserted mid-operation SHALL discard all slot contents and flags.
REQ-030 After rst_n deasserts, the first write SHALL be accepted on the next rising edge.

Verification
REQ-031 Reset, then write in=32'hA5A5_0001 with addr=3 and enable=0 -> out3=32'hA5A5_0001, valid=8'h08, count=1, all other outputs 0.
REQ-032 Fill slots 0..7 with values 0x10..0x17 -> valid=8'hFF, count=8, overflow=0; then write addr=5 with 0x99 and ack=0 -> out5=0x99, overflow=1, still 1 two cycles later.
REQ-033 valid[2]=1, then write addr=2 with 0x55 and ack=8'h04 in the same cycle -> valid[2]=1, out2=0x55, overflow=0; ack=8'h04 alone next cycle -> valid[2]=0, out2=0.
REQ-034 valid=8'h0F and overflow=1, then clear=1 plus write addr=6 with 0x77 -> valid=8'h40, out6=0x77, count=1, overflow=0.
REQ-035 With valid=8'hFF, assert rst_n=0 between clock edges -> outputs, valid, count and overflow reach 0 before the next edge; ack=8'hFF during reset has no effect.
REQ-036 enable=1 with addr toggling and in changing for 10 cycles -> valid, data and overflow unchanged.
